// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that lends one shared up-counter to
// NREQ requesters. The winner gets a counting run of its requested length
// (count shows 0..L-1), then a one-cycle done pulse.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous active-low reset
//   req    - per-requester run request (held high for the whole run)
//   len    - packed run lengths, slice [i*WIDTH +: WIDTH] belongs to requester i
//   grant  - one-hot owner of the counter, zero when idle
//   busy   - high whenever the FSM is not IDLE
//   count  - shared counter value
//   done   - one-cycle completion pulse to the owner
module counter_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       grant,
  output logic                  busy,
  output logic [WIDTH-1:0]      count,
  output logic [NREQ-1:0]       done
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, GRANT, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     winner_q, winner_d;
  logic [IW-1:0]     last_q, last_d;
  logic [IW-1:0]     arb_win;
  logic              arb_found;
  logic [WIDTH-1:0]  len_q, len_d;
  logic [WIDTH-1:0]  count_d;
  logic [NREQ-1:0]   grant_d, done_d;
  logic              busy_d;
  logic [WIDTH-1:0]  len_arr [NREQ];

  // Unpack the length bus into one entry per requester.
  for (genvar i = 0; i < NREQ; i++) begin : g_len
    assign len_arr[i] = len[i*WIDTH +: WIDTH];
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      if (!arb_found && req[IW'((32'(last_q) + k) % NREQ)]) begin
        arb_found = 1'b1;
        arb_win   = IW'((32'(last_q) + k) % NREQ);
      end
    end
  end

  // Next-state and next-output logic; outputs are registered from these.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    last_d   = last_q;
    len_d    = len_q;
    count_d  = count;
    grant_d  = grant;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (arb_found) begin
          state_d  = GRANT;
          winner_d = arb_win;
          len_d    = len_arr[arb_win];
          count_d  = '0;
          grant_d  = NREQ'(1) << arb_win;
        end
      end
      GRANT: begin
        if (!req[winner_q]) begin
          // Owner withdrew: abort without a done pulse.
          state_d = IDLE;
          last_d  = winner_q;
          grant_d = '0;
        end else if (len_q == '0) begin
          state_d = DONE;
          done_d  = grant;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req[winner_q]) begin
          state_d = IDLE;
          last_d  = winner_q;
          grant_d = '0;
        end else if (count == len_q - WIDTH'(1)) begin
          // Final value is held, so the counter never wraps.
          state_d = DONE;
          done_d  = grant;
        end else begin
          count_d = count + WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        last_d  = winner_q;
        grant_d = '0;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      winner_q <= '0;
      last_q   <= IW'(NREQ - 1);
      len_q    <= '0;
      count    <= '0;
      grant    <= '0;
      done     <= '0;
      busy     <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      last_q   <= last_d;
      len_q    <= len_d;
      count    <= count_d;
      grant    <= grant_d;
      done     <= done_d;
      busy     <= busy_d;
    end
  end

endmodule
